// File: rtl/memory_access.sv
// Memory access stage: passes ALU results through to writeback, and turns
// load/store ops into single word-aligned bus transactions with byte-lane
// strobes, stalling upstream until the bus acknowledges.
module memory_access #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            en_mem,
    input  logic            en_wb,
    input  logic            mem_write,
    input  logic            mem_read_unsigned,
    input  logic [1:0]      mem_size,
    input  logic [4:0]      reg_write,
    input  logic            write_pc,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] store_data,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack,
    output logic [XLEN-1:0] result,
    output logic [4:0]      reg_write_out,
    output logic            en_wb_out,
    output logic            write_pc_out,
    output logic            misaligned,
    output logic            stall
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic            r_bus_req;
    logic            r_bus_we;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_bus_wdata;
    logic [3:0]      r_bus_wstrb;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_reg_write_out;
    logic            r_en_wb_out;
    logic            r_write_pc_out;
    logic            r_misaligned;

    logic [1:0]      r_lane;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic            r_store;
    logic            r_en_wb;
    logic [4:0]      r_rd;
    logic            r_wpc;

    logic            w_misaligned;
    logic            w_accept;
    logic            w_stall;
    logic [XLEN-1:0] w_wdata;
    logic [3:0]      w_wstrb;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;

    // State register; reset always returns to IDLE, abandoning any access.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state, stall, alignment check, store lane formatting and load extraction.
    always_comb begin
        w_next       = r_state;
        w_misaligned = (mem_size == 2'b11) ||
                       ((mem_size == 2'b01) && addr[0]) ||
                       ((mem_size == 2'b10) && (addr[1:0] != 2'b00));
        w_accept     = en && en_mem && !w_misaligned;
        w_stall      = 1'b0;
        w_wdata      = store_data;
        w_wstrb      = 4'b0000;
        w_byte       = bus_rdata[{r_lane, 3'b000} +: 8];
        w_half       = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        w_load       = bus_rdata;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next  = BUSY;
                    w_stall = 1'b1;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (bus_ack) w_next = DONE;
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase

        if (!rst) w_stall = 1'b0;

        case (mem_size)
            2'b00:   w_wdata = {4{store_data[7:0]}};
            2'b01:   w_wdata = {2{store_data[15:0]}};
            default: w_wdata = store_data;
        endcase

        if (mem_write) begin
            case (mem_size)
                2'b00:   w_wstrb = 4'b0001 << addr[1:0];
                2'b01:   w_wstrb = 4'b0011 << addr[1:0];
                default: w_wstrb = 4'b1111;
            endcase
        end

        case (r_size)
            2'b00:   w_load = r_unsigned ? {{(XLEN-8){1'b0}}, w_byte}
                                         : {{(XLEN-8){w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {{(XLEN-16){1'b0}}, w_half}
                                         : {{(XLEN-16){w_half[15]}}, w_half};
            default: w_load = bus_rdata;
        endcase
        if (r_store) w_load = '0;
    end

    // Datapath registers: writeback pulses, captured op and bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bus_req       <= 1'b0;
            r_bus_we        <= 1'b0;
            r_bus_addr      <= '0;
            r_bus_wdata     <= '0;
            r_bus_wstrb     <= 4'b0000;
            r_result        <= '0;
            r_reg_write_out <= 5'd0;
            r_en_wb_out     <= 1'b0;
            r_write_pc_out  <= 1'b0;
            r_misaligned    <= 1'b0;
            r_lane          <= 2'b00;
            r_size          <= 2'b00;
            r_unsigned      <= 1'b0;
            r_store         <= 1'b0;
            r_en_wb         <= 1'b0;
            r_rd            <= 5'd0;
            r_wpc           <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_en_wb_out  <= 1'b0;
                    r_misaligned <= 1'b0;
                    if (en) begin
                        if (!en_mem) begin
                            r_result        <= addr;
                            r_reg_write_out <= reg_write;
                            r_en_wb_out     <= en_wb;
                            r_write_pc_out  <= write_pc;
                        end else if (w_misaligned) begin
                            r_misaligned    <= 1'b1;
                            r_reg_write_out <= reg_write;
                            r_write_pc_out  <= write_pc;
                        end else begin
                            r_lane      <= addr[1:0];
                            r_size      <= mem_size;
                            r_unsigned  <= mem_read_unsigned;
                            r_store     <= mem_write;
                            r_en_wb     <= en_wb;
                            r_rd        <= reg_write;
                            r_wpc       <= write_pc;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[XLEN-1:2], 2'b00};
                            r_bus_wdata <= w_wdata;
                            r_bus_wstrb <= w_wstrb;
                        end
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        r_bus_req       <= 1'b0;
                        r_result        <= w_load;
                        r_reg_write_out <= r_rd;
                        r_en_wb_out     <= r_en_wb;
                        r_write_pc_out  <= r_wpc;
                    end
                end
                DONE: begin
                    r_en_wb_out  <= 1'b0;
                    r_misaligned <= 1'b0;
                end
                default: r_en_wb_out <= 1'b0;
            endcase
        end
    end

    assign bus_req       = r_bus_req;
    assign bus_we        = r_bus_we;
    assign bus_addr      = r_bus_addr;
    assign bus_wdata     = r_bus_wdata;
    assign bus_wstrb     = r_bus_wstrb;
    assign result        = r_result;
    assign reg_write_out = r_reg_write_out;
    assign en_wb_out     = r_en_wb_out;
    assign write_pc_out  = r_write_pc_out;
    assign misaligned    = r_misaligned;
    assign stall         = w_stall;

endmodule
